// File: rtl/unidad_logica_checker.sv
// rtl/unidad_logica_checker.sv - exhaustive 16-vector self-checking sequencer for Unidad_Logica
module unidad_logica_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  output logic             op1_out,
  output logic             op2_out,
  input  logic             resultado_in,
  input  logic             cout_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] error_count,
  output logic             fail_valid,
  output logic [3:0]       first_fail
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Counter is loaded with S and counts down to 0, giving S+1 hold cycles per vector.
  localparam logic [3:0]       HOLD_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;
  localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       stim_q, stim_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fv_q, fv_d;
  logic [3:0]       ff_q, ff_d;
  logic             pass_q, pass_d;

  logic             exp_res;
  logic             exp_cout;
  logic             mismatch;

  // Reference model of the unit for the vector currently held on the stimulus pins.
  always_comb begin
    exp_res  = 1'b0;
    exp_cout = 1'b0;
    case (idx_q[3:2])
      2'b00: exp_res = idx_q[1] & idx_q[0];
      2'b01: exp_res = idx_q[1] | idx_q[0];
      2'b10: exp_res = idx_q[1] ^ idx_q[0];
      2'b11: begin
        exp_res  = idx_q[1] ^ idx_q[0];
        exp_cout = idx_q[1] & idx_q[0];
      end
      default: begin
        exp_res  = 1'b0;
        exp_cout = 1'b0;
      end
    endcase
  end

  assign mismatch = (resultado_in != exp_res) || (cout_in != exp_cout);

  // Next-state logic: sweep sequencing, hold timing and result bookkeeping.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    stim_d  = stim_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ff_d    = ff_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        stim_d = 4'd0;
        if (start) begin
          state_d = HOLD;
          idx_d   = 4'd0;
          cnt_d   = HOLD_LOAD;
          stim_d  = 4'd0;
          err_d   = '0;
          fv_d    = 1'b0;
          ff_d    = 4'd0;
          pass_d  = 1'b0;
        end
      end
      HOLD: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Last hold cycle: the unit has settled, judge this vector.
          if (mismatch) begin
            if (err_q != ERR_MAX) begin
              err_d = err_q + ERR_ONE;
            end
            if (!fv_q) begin
              fv_d = 1'b1;
              ff_d = idx_q;
            end
          end
          if (idx_q == 4'd15) begin
            state_d = FINISH;
            stim_d  = 4'd0;
            pass_d  = (err_q == '0) && !mismatch;
          end else begin
            idx_d  = idx_q + 4'd1;
            cnt_d  = HOLD_LOAD;
            stim_d = idx_q + 4'd1;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        stim_d  = 4'd0;
      end
      default: begin
        state_d = IDLE;
        stim_d  = 4'd0;
      end
    endcase
  end

  // State and result registers; reset aborts any sweep in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 4'd0;
      stim_q  <= 4'd0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ff_q    <= 4'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
    end
  end

  assign {op1_out, op2_out, a_out, b_out} = stim_q;
  assign busy        = (state_q == HOLD);
  assign done        = (state_q == FINISH);
  assign pass        = pass_q;
  assign error_count = err_q;
  assign fail_valid  = fv_q;
  assign first_fail  = ff_q;

endmodule

// File: tb/tb_unidad_logica_checker.sv
// tb/tb_unidad_logica_checker.sv - randomized self-checking bench for unidad_logica_checker
module tb_unidad_logica_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start_v [2];
  logic res_in_v [2];
  logic cout_in_v [2];

  logic a0, b0, o10, o20, busy0, done0, pass0, fv0;
  logic [4:0] ec0;
  logic [3:0] ff0;
  logic a1, b1, o11, o21, busy1, done1, pass1, fv1;
  logic [2:0] ec1;
  logic [3:0] ff1;

  unidad_logica_checker #(.SETTLE_CYCLES(2), .ERR_W(5)) dut (
    .clk(clk), .reset(rst), .start(start_v[0]),
    .a_out(a0), .b_out(b0), .op1_out(o10), .op2_out(o20),
    .resultado_in(res_in_v[0]), .cout_in(cout_in_v[0]),
    .busy(busy0), .done(done0), .pass(pass0),
    .error_count(ec0), .fail_valid(fv0), .first_fail(ff0)
  );

  unidad_logica_checker #(.SETTLE_CYCLES(1), .ERR_W(3)) dut_s1 (
    .clk(clk), .reset(rst), .start(start_v[1]),
    .a_out(a1), .b_out(b1), .op1_out(o11), .op2_out(o21),
    .resultado_in(res_in_v[1]), .cout_in(cout_in_v[1]),
    .busy(busy1), .done(done1), .pass(pass1),
    .error_count(ec1), .fail_valid(fv1), .first_fail(ff1)
  );

  logic [3:0] stim_v [2];
  logic       busy_v [2];
  logic       done_v [2];
  logic       pass_v [2];
  logic       fv_v [2];
  logic [4:0] ec_v [2];
  logic [3:0] ff_v [2];

  assign stim_v[0] = {o10, o20, a0, b0};
  assign stim_v[1] = {o11, o21, a1, b1};
  assign busy_v[0] = busy0;
  assign busy_v[1] = busy1;
  assign done_v[0] = done0;
  assign done_v[1] = done1;
  assign pass_v[0] = pass0;
  assign pass_v[1] = pass1;
  assign fv_v[0]   = fv0;
  assign fv_v[1]   = fv1;
  assign ec_v[0]   = ec0;
  assign ec_v[1]   = {2'b00, ec1};
  assign ff_v[0]   = ff0;
  assign ff_v[1]   = ff1;

  // Fault modes of the emulated unit: 0 correct, 1 stuck-at-0, 2 stuck-at-1, 3 flip on masked vectors.
  int          rmode [2];
  int          cmode [2];
  logic [15:0] rmask [2];
  logic [15:0] cmask [2];

  int n_vec = 0;
  int n_err = 0;

  // Behavioural unit: returns {cout, resultado} for stimulus {op1,op2,a,b}.
  function automatic logic [1:0] unit_out(input logic [3:0] v, input int rm, input int cm,
                                          input logic [15:0] rmk, input logic [15:0] cmk);
    int   a, b, sum;
    logic r, c;
    a = int'(v[1]);
    b = int'(v[0]);
    sum = a + b;
    c = 1'b0;
    case (v[3:2])
      2'd0: r = (a * b) != 0;
      2'd1: r = (a + b) != 0;
      2'd2: r = (sum % 2) != 0;
      default: begin
        r = (sum % 2) != 0;
        c = (sum / 2) != 0;
      end
    endcase
    if (rm == 1) r = 1'b0;
    else if (rm == 2) r = 1'b1;
    else if (rm == 3) r = r ^ rmk[v];
    if (cm == 1) c = 1'b0;
    else if (cm == 2) c = 1'b1;
    else if (cm == 3) c = c ^ cmk[v];
    return {c, r};
  endfunction

  assign {cout_in_v[0], res_in_v[0]} = unit_out(stim_v[0], rmode[0], cmode[0], rmask[0], cmask[0]);
  assign {cout_in_v[1], res_in_v[1]} = unit_out(stim_v[1], rmode[1], cmode[1], rmask[1], cmask[1]);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_zero(input int d, input string tag);
    check_eq({tag, "_stim"}, 32'(stim_v[d]), 0);
    check_eq({tag, "_busy"}, 32'(busy_v[d]), 0);
    check_eq({tag, "_done"}, 32'(done_v[d]), 0);
    check_eq({tag, "_pass"}, 32'(pass_v[d]), 0);
    check_eq({tag, "_ec"},   32'(ec_v[d]), 0);
    check_eq({tag, "_fv"},   32'(fv_v[d]), 0);
    check_eq({tag, "_ff"},   32'(ff_v[d]), 0);
  endtask

  int exp_ec_last;
  int exp_ff_last;

  // One sweep on instance d. abort_at >= 0 pulses reset after that edge; pokes re-asserts
  // start at edges 10 and 30; b2b asserts start in the done cycle.
  task automatic run_sweep(input int d, input bit b2b, input int abort_at, input bit pokes);
    int s, w, last, cnt, first, sat, exp_ec;
    logic [1:0] g, u;
    s = (d == 0) ? 2 : 1;
    w = (d == 0) ? 5 : 3;
    last = 16 * (s + 1);
    cnt = 0;
    first = 0;
    for (int i = 0; i < 16; i++) begin
      g = unit_out(4'(i), 0, 0, 16'h0, 16'h0);
      u = unit_out(4'(i), rmode[d], cmode[d], rmask[d], cmask[d]);
      if (g != u) begin
        if (cnt == 0) first = i;
        cnt++;
      end
    end
    sat = (1 << w) - 1;
    exp_ec = (cnt > sat) ? sat : cnt;
    exp_ec_last = exp_ec;
    exp_ff_last = first;

    @(negedge clk);
    start_v[d] = 1'b1;
    @(posedge clk);
    #1;
    start_v[d] = 1'b0;
    for (int n = 0; ; n++) begin
      if (n == abort_at) begin
        rst = 1'b1;
        #1;
        check_idle_zero(d, "abort");
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
      if (n < last) begin
        check_eq("hold_stim", 32'(stim_v[d]), 32'(n / (s + 1)));
        check_eq("hold_busy", 32'(busy_v[d]), 1);
        check_eq("hold_done", 32'(done_v[d]), 0);
        if (n == 0) begin
          check_eq("start_ec", 32'(ec_v[d]), 0);
          check_eq("start_fv", 32'(fv_v[d]), 0);
          check_eq("start_pass", 32'(pass_v[d]), 0);
        end
      end else begin
        check_eq("fin_done", 32'(done_v[d]), 1);
        check_eq("fin_busy", 32'(busy_v[d]), 0);
        check_eq("fin_stim", 32'(stim_v[d]), 0);
        check_eq("fin_pass", 32'(pass_v[d]), 32'(cnt == 0));
        check_eq("fin_ec",   32'(ec_v[d]), 32'(exp_ec));
        check_eq("fin_fv",   32'(fv_v[d]), 32'(cnt > 0));
        check_eq("fin_ff",   32'(ff_v[d]), 32'(first));
      end
      if (n == last) begin
        start_v[d] = b2b;
        break;
      end
      start_v[d] = pokes && ((n + 1 == 10) || (n + 1 == 30));
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    start_v[d] = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", 32'(busy_v[d]), 0);
    check_eq("idle_done", 32'(done_v[d]), 0);
    check_eq("idle_pass", 32'(pass_v[d]), 32'(cnt == 0));
    check_eq("idle_ec",   32'(ec_v[d]), 32'(exp_ec));
  endtask

  task automatic set_unit(input int d, input int rm, input int cm,
                          input logic [15:0] rmk, input logic [15:0] cmk);
    rmode[d] = rm;
    cmode[d] = cm;
    rmask[d] = rmk;
    cmask[d] = cmk;
  endtask

  initial begin
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    set_unit(0, 0, 0, 16'h0, 16'h0);
    set_unit(1, 0, 0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero(0, "rst0");
    check_idle_zero(1, "rst1");
    rst = 1'b0;

    run_sweep(0, 1'b1, -1, 1'b0);
    run_sweep(0, 1'b0, -1, 1'b0);

    set_unit(0, 1, 0, 16'h0, 16'h0);
    run_sweep(0, 1'b0, -1, 1'b0);
    check_eq("plan_stuck0_ec", 32'(ec_v[0]), 8);
    check_eq("plan_stuck0_ff", 32'(ff_v[0]), 3);

    set_unit(0, 0, 0, 16'h0, 16'h0);
    run_sweep(0, 1'b0, -1, 1'b1);
    run_sweep(0, 1'b0, 20, 1'b0);
    run_sweep(0, 1'b0, -1, 1'b0);
    check_eq("plan_post_abort_pass", 32'(pass_v[0]), 1);

    set_unit(1, 0, 2, 16'h0, 16'h0);
    run_sweep(1, 1'b1, -1, 1'b0);
    check_eq("plan_cout1_ec", 32'(ec_v[1]), 7);
    check_eq("plan_cout1_ff", 32'(ff_v[1]), 0);
    set_unit(1, 0, 0, 16'h0, 16'h0);
    run_sweep(1, 1'b0, -1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      int d;
      d = int'($urandom_range(0, 1));
      set_unit(d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               16'($urandom), 16'($urandom));
      run_sweep(d, 1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)));
      check_eq("rand_ff_hold", 32'(ff_v[d]), 32'(exp_ff_last));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/unidad_logica_checker.md
# unidad_logica_checker

Sequential self-checking sequencer for the `Unidad_Logica` block. It drives the 16 combinations of `a`, `b`, `op1` and `op2` in order, holding each one for a programmable settle time. It samples `resultado`/`cout` back and compares them against a built-in reference model. It sits opposite the unit under test, receiving its outputs, and reports pass/fail, an error count and the first failing vector to on-board indicators or a bench.

## Interface
Parameters:
- `SETTLE_CYCLES`, 2: cycles each vector is held before its compare; legal range 1..15.
- `ERR_W`, 5: width of the error counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- `a_out`, `b_out`, `op1_out`, `op2_out`  out  1 each  stimulus to the unit; registered.
- `resultado_in`  in  1  unit result.
- `cout_in`  in  1  unit carry.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse when the sweep completes.
- `pass`  out  1  high when the last completed sweep had zero errors.
- `error_count`  out  ERR_W  count of failing vectors; saturating.
- `fail_valid`  out  1  at least one mismatch in the current or last sweep.
- `first_fail`  out  4  index of the first failing vector.

## Operation
- Vector index `idx[3:0]` maps as follows: `{op1_out,op2_out}=idx[3:2]`, `a_out=idx[1]`, `b_out=idx[0]`. The sweep runs idx 0 to 15 ascending.
- Reference model, selected by `{op1,op2}`:
  - 00: `resultado=a&b`, `cout=0`
  - 01: `resultado=a|b`, `cout=0`
  - 10: `resultado=a^b`, `cout=0`
  - 11: 1-bit add, `resultado=a^b`, `cout=a&b`
- A vector fails if either output mismatches. Each failing vector counts once.
- FSM states are IDLE, HOLD and FINISH.
- **IDLE**
  - Stimulus outputs are 0 and `busy=0`.
  - On `start=1`: set idx=0, clear `error_count`, `fail_valid`, `first_fail` and `pass`, load the hold counter, and go to HOLD.
- **HOLD**
  - The stimulus equals idx. The hold counter runs SETTLE_CYCLES+1 cycles.
  - On the edge ending the last hold cycle, compare `resultado_in`/`cout_in` against the model for idx.
  - On a mismatch, increment `error_count`, saturating at 2^ERR_W-1. If `fail_valid=0`, set `first_fail=idx` and `fail_valid=1`.
  - If idx=15, go to FINISH. Otherwise increment idx and reload the counter.
- **FINISH**
  - For one cycle: `done=1`, `busy=0`, stimulus 0, and `pass=(error_count==0)`. Then go to IDLE.
- `pass`, `error_count`, `fail_valid` and `first_fail` hold their values in IDLE until the next accepted `start`.
- `start` while busy is ignored. There is no restart mid-sweep.

## Timing
- Reset values: all outputs 0, FSM in IDLE, idx=0, counters 0. Reset asserted mid-sweep aborts immediately, asynchronously.
- Let the edge that samples `start=1` be edge 0:
  - Vector 0 appears after edge 0.
  - Vector k is driven from edge k·(S+1) to edge (k+1)·(S+1), where S=SETTLE_CYCLES.
  - The compare for vector k happens at edge (k+1)·(S+1).
  - `done` is high in the cycle after edge 16·(S+1). With S=2 that is edge 48.
- Stimulus changes only at the compare edges, so there are no glitches between vectors.
- `resultado_in`/`cout_in` are sampled directly. The unit must settle within S+1 cycles minus routing.
- Back-to-back sweeps: `start` in the `done` cycle is ignored because the FSM is not yet in IDLE. `start` one cycle later is accepted.

## Test plan
- Correct combinational model of the unit, S=2, `start` at edge 0 -> 16 vectors in order, `done` pulse after edge 48, `pass=1`, `error_count=0`, `fail_valid=0`.
- `resultado_in` stuck at 0 -> failures at idx 3,5,6,7,9,10,13,14; `error_count=8`, `first_fail=3`, `pass=0`.
- `cout_in` stuck at 1 with ERR_W=3 -> 15 failures (all except idx 15); `error_count` saturates at 7, `first_fail=0`.
- `reset` pulsed at edge 20 of a sweep -> all outputs 0 immediately. A new `start` then gives a full clean sweep with `pass=1`.
- `start` re-asserted at edges 10 and 30 during a sweep -> no effect; `done` still follows edge 48.
- S=1 -> each vector held 2 cycles, `done` follows edge 32. `start` in the `done` cycle is ignored; `start` one cycle later is accepted.
